// File: rtl/byte_pair_sequencer_pkg.sv
// Shared definitions for the byte pair sequencer: FSM encoding and counter widths.
package byte_pair_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int TIMEOUT_CNT_W      = 8;
   localparam int PAIR_CNT_W         = 16;

   typedef enum logic [2:0] {
      ST_GET_A     = 3'd0,
      ST_GET_B     = 3'd1,
      ST_LAUNCH    = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_HOLD      = 3'd4
   } bp_state_e;

endpackage

// File: rtl/byte_pair_sequencer_done_timeout_counter.sv
// Counts WAIT_DONE cycles; expired_o is high during the last permitted cycle.
module done_timeout_counter
   import byte_pair_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TIMEOUT_CNT_W-1:0] LAST_CNT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_CNT_W-1:0] count_q;
   logic [TIMEOUT_CNT_W-1:0] count_d;

   // The FSM leaves WAIT_DONE on expiry, so the count never needs to roll over.
   assign expired_o = enable_i && (count_q == LAST_CNT);

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/byte_pair_sequencer.sv
// Pairs incoming bytes as A/B, launches one parity operation per pair and
// presents the captured result on a valid/ready output with a timeout guard.
module byte_pair_sequencer
   import byte_pair_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] byte_a,
   output logic [DATA_WIDTH-1:0] byte_b,
   output logic                  start,
   input  logic                  done,
   input  logic [DATA_WIDTH-1:0] byte_parity,
   output logic [DATA_WIDTH-1:0] out_parity,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  timeout_err,
   output logic [PAIR_CNT_W-1:0] pair_count,
   output logic [2:0]            dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; valid-side data and valid stay stable until that transfer.

   bp_state_e             state_q;
   logic                  in_ready_q;
   logic [DATA_WIDTH-1:0] byte_a_q;
   logic [DATA_WIDTH-1:0] byte_b_q;
   logic                  start_q;
   logic [DATA_WIDTH-1:0] out_parity_q;
   logic                  out_valid_q;
   logic                  timeout_err_q;
   logic [PAIR_CNT_W-1:0] pair_count_q;
   logic [PAIR_CNT_W-1:0] pair_count_d;
   logic                  tmo_clear;
   logic                  tmo_enable;
   logic                  tmo_expired;

   assign tmo_clear    = (state_q == ST_LAUNCH);
   assign tmo_enable   = (state_q == ST_WAIT_DONE);
   assign pair_count_d = pair_count_q + 1'b1;

   done_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (tmo_clear),
      .enable_i (tmo_enable),
      .expired_o(tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_GET_A;
         in_ready_q    <= 1'b0;
         byte_a_q      <= '0;
         byte_b_q      <= '0;
         start_q       <= 1'b0;
         out_parity_q  <= '0;
         out_valid_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         pair_count_q  <= '0;
      end else begin
         start_q       <= 1'b0;
         timeout_err_q <= 1'b0;
         case (state_q)
            ST_GET_A: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  byte_a_q <= in_data;
                  state_q  <= ST_GET_B;
               end
            end
            ST_GET_B: begin
               if (in_valid && in_ready_q) begin
                  byte_b_q   <= in_data;
                  in_ready_q <= 1'b0;
                  start_q    <= 1'b1;
                  state_q    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               // done takes priority over a simultaneous expiry
               if (done) begin
                  out_parity_q <= byte_parity;
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_HOLD;
               end else if (tmo_expired) begin
                  timeout_err_q <= 1'b1;
                  in_ready_q    <= 1'b1;
                  state_q       <= ST_GET_A;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_q  <= 1'b0;
                  pair_count_q <= pair_count_d;
                  in_ready_q   <= 1'b1;
                  state_q      <= ST_GET_A;
               end
            end
            default: begin
               in_ready_q <= 1'b0;
               state_q    <= ST_GET_A;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign byte_a      = byte_a_q;
   assign byte_b      = byte_b_q;
   assign start       = start_q;
   assign out_parity  = out_parity_q;
   assign out_valid   = out_valid_q;
   assign timeout_err = timeout_err_q;
   assign pair_count  = pair_count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_byte_pair_sequencer.sv
// Directed bench for byte_pair_sequencer: nominal, backpressure, timeout,
// collision, reset abandonment, stray done and counter wrap.
module tb_byte_pair_sequencer;
   import byte_pair_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  byte_a;
   logic [7:0]  byte_b;
   logic        start;
   logic        done;
   logic [7:0]  byte_parity;
   logic [7:0]  out_parity;
   logic        out_valid;
   logic        out_ready;
   logic        timeout_err;
   logic [15:0] pair_count;
   logic [2:0]  dbg_state;

   int vec_cnt = 0;
   int err_cnt = 0;
   int tmo_cnt;

   always #5 clk = ~clk;

   byte_pair_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .byte_a     (byte_a),
      .byte_b     (byte_b),
      .start      (start),
      .done       (done),
      .byte_parity(byte_parity),
      .out_parity (out_parity),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .timeout_err(timeout_err),
      .pair_count (pair_count),
      .dbg_state_o(dbg_state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_byte_a"}, byte_a, 0);
      chk({tag, "_byte_b"}, byte_b, 0);
      chk({tag, "_start"}, start, 0);
      chk({tag, "_out_parity"}, out_parity, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
      chk({tag, "_pair_count"}, pair_count, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
   endtask

   initial begin
      reset_n     = 1'b0;
      in_data     = '0;
      in_valid    = 1'b0;
      done        = 1'b0;
      byte_parity = '0;
      out_ready   = 1'b1;

      // Reset state
      step();
      step();
      chk_all_zero("rst");
      chk("rst_state", dbg_state, ST_GET_A);
      reset_n = 1'b1;
      step();
      chk("rel_in_ready", in_ready, 1);

      // Nominal pair: done two cycles after start
      send_byte(8'hA5);
      chk("nom_getb_state", dbg_state, ST_GET_B);
      send_byte(8'h3C);
      chk("nom_start_hi", start, 1);
      chk("nom_launch_in_ready", in_ready, 0);
      step();
      chk("nom_start_lo", start, 0);
      chk("nom_byte_a", byte_a, 8'hA5);
      chk("nom_byte_b", byte_b, 8'h3C);
      step();
      chk("nom_wait_valid", out_valid, 0);
      done        = 1'b1;
      byte_parity = 8'h99;
      step();
      done = 1'b0;
      chk("nom_out_valid", out_valid, 1);
      chk("nom_out_parity", out_parity, 8'h99);
      chk("nom_count_pre", pair_count, 0);
      step();
      chk("nom_count", pair_count, 1);
      chk("nom_valid_drop", out_valid, 0);
      chk("nom_in_ready", in_ready, 1);

      // Output backpressure for 10 cycles
      out_ready = 1'b0;
      send_byte(8'h11);
      send_byte(8'h22);
      step();
      done        = 1'b1;
      byte_parity = 8'h5A;
      step();
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_parity", out_parity, 8'h5A);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_count", pair_count, 1);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("bp_release_count", pair_count, 2);
      chk("bp_release_valid", out_valid, 0);
      chk("bp_hold_parity", out_parity, 8'h5A);

      // Timeout: done never arrives
      send_byte(8'h01);
      send_byte(8'h02);
      chk("tmo_start", start, 1);
      step();
      tmo_cnt = 0;
      repeat (15) begin
         step();
         if (timeout_err) tmo_cnt++;
      end
      chk("tmo_early", timeout_err, 0);
      chk("tmo_w16_state", dbg_state, ST_WAIT_DONE);
      step();
      chk("tmo_pulse", timeout_err, 1);
      chk("tmo_in_ready", in_ready, 1);
      chk("tmo_state", dbg_state, ST_GET_A);
      chk("tmo_count", pair_count, 2);
      chk("tmo_no_valid", out_valid, 0);
      if (timeout_err) tmo_cnt++;
      step();
      chk("tmo_pulse_end", timeout_err, 0);
      chk("tmo_pulses", tmo_cnt, 1);

      // Done coincides with expiry
      send_byte(8'h03);
      send_byte(8'h04);
      step();
      repeat (15) step();
      done        = 1'b1;
      byte_parity = 8'hC3;
      step();
      done = 1'b0;
      chk("col_out_valid", out_valid, 1);
      chk("col_out_parity", out_parity, 8'hC3);
      chk("col_no_err", timeout_err, 0);
      step();
      chk("col_count", pair_count, 3);
      chk("col_no_err2", timeout_err, 0);

      // Reset during WAIT_DONE, then a late done
      send_byte(8'h05);
      send_byte(8'h06);
      step();
      reset_n = 1'b0;
      step();
      chk_all_zero("rstw");
      reset_n = 1'b1;
      step();
      chk("rstw_in_ready", in_ready, 1);
      done        = 1'b1;
      byte_parity = 8'hFF;
      step();
      done = 1'b0;
      chk("rstw_late_valid", out_valid, 0);
      chk("rstw_late_parity", out_parity, 0);
      chk("rstw_state", dbg_state, ST_GET_A);
      tmo_cnt = 0;
      repeat (20) begin
         step();
         if (timeout_err || start) tmo_cnt++;
      end
      chk("rstw_quiet", tmo_cnt, 0);

      // Reset during HOLD
      out_ready = 1'b0;
      send_byte(8'h07);
      send_byte(8'h08);
      step();
      done        = 1'b1;
      byte_parity = 8'h77;
      step();
      done = 1'b0;
      chk("rsth_valid", out_valid, 1);
      reset_n = 1'b0;
      step();
      chk_all_zero("rsth");
      reset_n   = 1'b1;
      out_ready = 1'b1;
      step();
      chk("rsth_in_ready", in_ready, 1);

      // done during LAUNCH is ignored
      send_byte(8'h09);
      send_byte(8'h0A);
      done        = 1'b1;
      byte_parity = 8'hEE;
      step();
      done = 1'b0;
      chk("lch_no_capture", out_valid, 0);
      chk("lch_state", dbg_state, ST_WAIT_DONE);
      done        = 1'b1;
      byte_parity = 8'h12;
      step();
      done = 1'b0;
      chk("lch_parity", out_parity, 8'h12);
      step();
      chk("lch_count", pair_count, 1);

      // Counter wrap with a stray done in GET_A
      force dut.pair_count_q = 16'hFFFF;
      step();
      release dut.pair_count_q;
      step();
      chk("wrap_preload", pair_count, 16'hFFFF);
      done        = 1'b1;
      byte_parity = 8'hAB;
      step();
      done = 1'b0;
      chk("stray_valid", out_valid, 0);
      chk("stray_parity", out_parity, 8'h12);
      chk("stray_state", dbg_state, ST_GET_A);
      send_byte(8'h0B);
      send_byte(8'h0C);
      step();
      done        = 1'b1;
      byte_parity = 8'h34;
      step();
      done = 1'b0;
      chk("wrap_parity", out_parity, 8'h34);
      chk("wrap_count_pre", pair_count, 16'hFFFF);
      step();
      chk("wrap_count", pair_count, 16'h0000);
      chk("wrap_in_ready", in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
